// File: rtl/anita3_trigger_arbiter_pkg.sv
// anita3_trig_pkg: shared constants for the ANITA-3 trigger arbiter.
//   SRC_*          source index of each trigger input bit
//   state_e        arbiter FSM states
//   DEF_*          default widths for the arbiter, interface and counters
package anita3_trig_pkg;

  localparam int unsigned SRC_RF   = 0;
  localparam int unsigned SRC_PPS1 = 1;
  localparam int unsigned SRC_PPS2 = 2;
  localparam int unsigned SRC_SOFT = 3;

  localparam int unsigned DEF_NUM_SRC      = 4;
  localparam int unsigned DEF_HOLDOFF_BITS = 8;
  localparam int unsigned DEF_CNT_BITS     = 16;
  localparam int unsigned LOST_ADDR_BITS   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/anita3_trigger_arbiter_if.sv
// anita3_trig_if: bundle between the trigger sources / readout side and the
// arbiter.
//   req_i, en_i        per-source request pulses and enables
//   holdoff_i, dead_i  holdoff length and buffer-manager dead flag
//   trig_o             one-hot single-cycle trigger
//   busy_o, pending_o  FSM-not-idle flag and pending request flags
//   lost_addr_i/_clr_i lost-counter select and clear
//   lost_dat_o         selected lost counter (registered)
// master: trigger sources / readout; slave: the arbiter.
interface anita3_trig_if
  import anita3_trig_pkg::*;
#(
  parameter int unsigned NUM_SRC      = DEF_NUM_SRC,
  parameter int unsigned HOLDOFF_BITS = DEF_HOLDOFF_BITS,
  parameter int unsigned CNT_BITS     = DEF_CNT_BITS
);
  logic [NUM_SRC-1:0]        req_i;
  logic [NUM_SRC-1:0]        en_i;
  logic [HOLDOFF_BITS-1:0]   holdoff_i;
  logic                      dead_i;
  logic [NUM_SRC-1:0]        trig_o;
  logic                      busy_o;
  logic [NUM_SRC-1:0]        pending_o;
  logic [LOST_ADDR_BITS-1:0] lost_addr_i;
  logic [CNT_BITS-1:0]       lost_dat_o;
  logic                      lost_clr_i;

  modport master (
    output req_i, en_i, holdoff_i, dead_i, lost_addr_i, lost_clr_i,
    input  trig_o, busy_o, pending_o, lost_dat_o
  );

  modport slave (
    input  req_i, en_i, holdoff_i, dead_i, lost_addr_i, lost_clr_i,
    output trig_o, busy_o, pending_o, lost_dat_o
  );
endinterface

// File: rtl/anita3_trigger_arbiter_sat_counter.sv
// anita3_sat_counter: saturating up-counter for lost-request accounting.
//   clk_i    clock
//   rst_n_i  synchronous active-low reset
//   inc_i    increment request (ignored once at all-ones)
//   clr_i    synchronous clear, takes precedence over inc_i
//   cnt_o    current count
module anita3_sat_counter #(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                inc_i,
  input  logic                clr_i,
  output logic [CNT_BITS-1:0] cnt_o
);
  logic [CNT_BITS-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                   cnt_q <= '0;
    else if (clr_i)                 cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/anita3_trigger_arbiter.sv
// anita3_trigger_arbiter: latches per-source trigger requests, issues them
// one at a time in fixed priority (bit 0 highest) while the buffer manager
// is not dead, enforces a holdoff after each trigger, and counts requests
// that coalesced into an already-pending flag.
//   clk250_i  250 MHz clock, rising edge
//   rst_n_i   synchronous active-low reset
//   bus       anita3_trig_if slave: requests, enables, holdoff, dead,
//             trigger out, busy/pending status, lost-counter readout
module anita3_trigger_arbiter
  import anita3_trig_pkg::*;
#(
  parameter int unsigned NUM_SRC      = DEF_NUM_SRC,
  parameter int unsigned HOLDOFF_BITS = DEF_HOLDOFF_BITS,
  parameter int unsigned CNT_BITS     = DEF_CNT_BITS
) (
  input  logic          clk250_i,
  input  logic          rst_n_i,
  anita3_trig_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [HOLDOFF_BITS-1:0] hcnt_q, hcnt_d;
  logic [NUM_SRC-1:0]      pend_q, pend_d;
  logic [NUM_SRC-1:0]      grant_clr;
  logic [NUM_SRC-1:0]      lost_inc;
  logic [NUM_SRC-1:0]      trig;
  logic [IDX_W-1:0]        enc_idx;
  logic [CNT_BITS-1:0]     cnt [NUM_SRC];
  logic [CNT_BITS-1:0]     lost_q;

  // Lowest-index pending source wins.
  always_comb begin
    enc_idx = '0;
    for (int unsigned k = NUM_SRC; k > 0; k--) begin
      if (pend_q[k-1]) enc_idx = IDX_W'(k-1);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hcnt_d    = hcnt_q;
    trig      = '0;
    grant_clr = '0;
    unique case (state_q)
      IDLE: begin
        if ((|pend_q) && !bus.dead_i) begin
          grant_d = enc_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        trig[grant_q]      = 1'b1;
        grant_clr[grant_q] = 1'b1;
        hcnt_d             = bus.holdoff_i;
        state_d            = (bus.holdoff_i == '0) ? IDLE : HOLDOFF;
      end
      HOLDOFF: begin
        if (hcnt_q != '0) hcnt_d = hcnt_q - 1'b1;
        if (hcnt_q <= HOLDOFF_BITS'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new request beats a same-cycle grant clear; a disable flushes.
  always_comb begin
    pend_d   = (bus.req_i & bus.en_i) | (pend_q & bus.en_i & ~grant_clr);
    lost_inc = bus.req_i & bus.en_i & pend_q & ~grant_clr;
  end

  always_ff @(posedge clk250_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      hcnt_q  <= '0;
      pend_q  <= '0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hcnt_q  <= hcnt_d;
      pend_q  <= pend_d;
      lost_q  <= cnt[bus.lost_addr_i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lost
    anita3_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk_i   (clk250_i),
      .rst_n_i (rst_n_i),
      .inc_i   (lost_inc[g]),
      .clr_i   (bus.lost_clr_i),
      .cnt_o   (cnt[g])
    );
  end

  assign bus.trig_o     = trig;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.pending_o  = pend_q;
  assign bus.lost_dat_o = lost_q;
endmodule

// File: tb/tb_anita3_trigger_arbiter.sv
module tb_anita3_trigger_arbiter;
  import anita3_trig_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #2 clk = ~clk;

  anita3_trig_if #(.NUM_SRC(4), .HOLDOFF_BITS(8), .CNT_BITS(16)) bus ();

  anita3_trigger_arbiter #(.NUM_SRC(4), .HOLDOFF_BITS(8), .CNT_BITS(16)) dut (
    .clk250_i (clk),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  // Each tick ends the current cycle; on return we are 1 time unit into the
  // next cycle, where outputs are sampled and inputs for that cycle are set.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_i = '0; bus.en_i = '1; bus.holdoff_i = '0; bus.dead_i = 1'b0;
    bus.lost_addr_i = '0; bus.lost_clr_i = 1'b0;
    rst_n = 1'b0;
    tick(); tick(); tick();
    total++; if (bus.trig_o !== 4'b0) begin bad++; $display("FAIL reset_trig got=%b want=0000", bus.trig_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.pending_o !== 4'b0) begin bad++; $display("FAIL reset_pending got=%b want=0000", bus.pending_o); end
    total++; if (bus.lost_dat_o !== 16'h0) begin bad++; $display("FAIL reset_lost got=%h want=0000", bus.lost_dat_o); end
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_fixed_priority();
    logic [3:0] exp;
    bus.holdoff_i = 8'd0; bus.en_i = 4'b1111;
    bus.req_i = 4'b1111;
    tick();
    bus.req_i = 4'b0000;
    total++; if (bus.pending_o !== 4'b1111) begin bad++; $display("FAIL prio_pending got=%b want=1111", bus.pending_o); end
    for (int i = 1; i <= 10; i++) begin
      exp = (i == 2) ? 4'b0001 : (i == 4) ? 4'b0010 : (i == 6) ? 4'b0100 : (i == 8) ? 4'b1000 : 4'b0000;
      total++; if (bus.trig_o !== exp) begin bad++; $display("FAIL prio_trig cycle=%0d got=%b want=%b", i, bus.trig_o, exp); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      bus.lost_addr_i = 2'(k);
      tick();
      total++; if (bus.lost_dat_o !== 16'h0) begin bad++; $display("FAIL prio_lost src=%0d got=%0d want=0", k, bus.lost_dat_o); end
    end
  endtask

  task automatic test_holdoff();
    int times[$];
    bus.holdoff_i = 8'd10; bus.lost_addr_i = 2'd0;
    for (int i = 0; i < 56; i++) begin
      bus.req_i = (i < 30) ? 4'b0001 : 4'b0000;
      tick();
      if (bus.trig_o[0]) times.push_back(i + 1);
    end
    bus.req_i = '0;
    total++; if (times.size() != 4) begin bad++; $display("FAIL holdoff_count got=%0d want=4", times.size()); end
    for (int j = 0; j < 4 && j < times.size(); j++) begin
      total++;
      if (times[j] != 2 + 12 * j) begin bad++; $display("FAIL holdoff_time idx=%0d got=%0d want=%0d", j, times[j], 2 + 12 * j); end
    end
    tick();
    total++; if (bus.lost_dat_o !== 16'd26) begin bad++; $display("FAIL holdoff_lost got=%0d want=26", bus.lost_dat_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL holdoff_idle got=%b want=0", bus.busy_o); end
  endtask

  task automatic test_dead();
    bus.holdoff_i = 8'd0; bus.dead_i = 1'b1;
    bus.req_i = 4'b1000; tick();
    bus.req_i = 4'b0001; tick();
    bus.req_i = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.trig_o !== 4'b0) begin bad++; $display("FAIL dead_stall cycle=%0d got=%b want=0000", i, bus.trig_o); end
      tick();
    end
    total++; if (bus.pending_o !== 4'b1001) begin bad++; $display("FAIL dead_pending got=%b want=1001", bus.pending_o); end
    bus.dead_i = 1'b0;
    tick();
    total++; if (bus.trig_o !== 4'b0001) begin bad++; $display("FAIL dead_rel_m1 got=%b want=0001", bus.trig_o); end
    tick();
    total++; if (bus.trig_o !== 4'b0000) begin bad++; $display("FAIL dead_rel_m2 got=%b want=0000", bus.trig_o); end
    tick();
    total++; if (bus.trig_o !== 4'b1000) begin bad++; $display("FAIL dead_rel_m3 got=%b want=1000", bus.trig_o); end
    tick(); tick();
  endtask

  task automatic test_enable();
    bus.en_i = 4'b1110;
    bus.req_i = 4'b0001; tick();
    bus.req_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.pending_o !== 4'b0000) begin bad++; $display("FAIL en_pending cycle=%0d got=%b want=0000", i, bus.pending_o); end
      total++; if (bus.trig_o !== 4'b0000) begin bad++; $display("FAIL en_trig cycle=%0d got=%b want=0000", i, bus.trig_o); end
      tick();
    end
    bus.dead_i = 1'b1;
    bus.req_i = 4'b0100; tick();
    bus.req_i = 4'b0000;
    total++; if (bus.pending_o !== 4'b0100) begin bad++; $display("FAIL en_set2 got=%b want=0100", bus.pending_o); end
    bus.en_i = 4'b1010; tick();
    total++; if (bus.pending_o !== 4'b0000) begin bad++; $display("FAIL en_flush2 got=%b want=0000", bus.pending_o); end
    bus.en_i = 4'b1111; bus.dead_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturation();
    bus.holdoff_i = 8'd0; bus.dead_i = 1'b1; bus.lost_addr_i = 2'd3;
    bus.req_i = 4'b1000;
    for (int i = 0; i < 70001; i++) tick();
    bus.req_i = 4'b0000;
    tick();
    total++; if (bus.lost_dat_o !== 16'hFFFF) begin bad++; $display("FAIL sat_lost got=%h want=ffff", bus.lost_dat_o); end
    total++; if (bus.pending_o !== 4'b1000) begin bad++; $display("FAIL sat_pending got=%b want=1000", bus.pending_o); end
    bus.req_i = 4'b1000; bus.lost_clr_i = 1'b1;
    tick();
    bus.req_i = 4'b0000; bus.lost_clr_i = 1'b0;
    tick();
    total++; if (bus.lost_dat_o !== 16'h0) begin bad++; $display("FAIL clr_beats_inc got=%h want=0000", bus.lost_dat_o); end
    bus.dead_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset_mid();
    bus.holdoff_i = 8'd20; bus.en_i = 4'b1111; bus.dead_i = 1'b0;
    bus.req_i = 4'b0001; tick();
    bus.req_i = 4'b0000; tick();
    total++; if (bus.trig_o !== 4'b0001) begin bad++; $display("FAIL rst_issue got=%b want=0001", bus.trig_o); end
    tick();
    bus.req_i = 4'b0110; bus.lost_addr_i = 2'd1; tick();
    tick();
    bus.req_i = 4'b0000; tick();
    total++; if (bus.lost_dat_o !== 16'd1) begin bad++; $display("FAIL rst_prelost got=%0d want=1", bus.lost_dat_o); end
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL rst_prebusy got=%b want=1", bus.busy_o); end
    total++; if (bus.pending_o !== 4'b0110) begin bad++; $display("FAIL rst_prepend got=%b want=0110", bus.pending_o); end
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.pending_o !== 4'b0000) begin bad++; $display("FAIL rst_pending got=%b want=0000", bus.pending_o); end
    total++; if (bus.trig_o !== 4'b0000) begin bad++; $display("FAIL rst_trig got=%b want=0000", bus.trig_o); end
    total++; if (bus.lost_dat_o !== 16'h0) begin bad++; $display("FAIL rst_lostq got=%h want=0000", bus.lost_dat_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.trig_o !== 4'b0000) begin bad++; $display("FAIL rst_after cycle=%0d got=%b want=0000", i, bus.trig_o); end
    end
    total++; if (bus.lost_dat_o !== 16'h0) begin bad++; $display("FAIL rst_lostcnt got=%h want=0000", bus.lost_dat_o); end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_holdoff();
    test_dead();
    test_enable();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
